icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache that answers the instruction-fetch side of the datapath cache interface and fills itself from the memory side. It asserts `ihit` and `imemload` for the datapath's `imemREN`/`imemaddr`. On a miss it issues a single-word read to memory, waits on `iwait`, installs the word, then hits. It sits between the pipelined datapath and the memory controller/arbiter.

## Interface
Parameters:
- NSETS, 16, number of one-word frames; power of two, ≥2. IDX = log2(NSETS), TAG = 30 − IDX.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  datapath fetch byte address (bits [1:0] ignored)
- ihit  out  1  requested word valid this cycle
- imemload  out  32  instruction word
- iREN  out  1  memory read request
- iaddr  out  32  memory read word address
- iwait  in  1  memory busy; low = `iload` valid this cycle
- iload  in  32  memory read data

## Operation
- Address split: tag = imemaddr[31:IDX+2], index = imemaddr[IDX+1:2].
- Each frame holds a valid bit, a TAG-bit tag and a 32-bit data word. Reset clears all valid bits. Data and tag reset to 0.
- FSM has two states, IDLE and FILL. Reset state is IDLE.
- IDLE, hit case:
  - Condition: imemREN=1 and frame[index] valid with tag equal.
  - ihit=1 combinationally; imemload = frame data.
  - State remains IDLE.
- IDLE, miss case:
  - Condition: imemREN=1 and not hit.
  - ihit=0; latch imemaddr[31:2] into miss_addr; next state FILL.
- IDLE with imemREN=0: ihit=0, no state change.
- FILL:
  - iREN=1, iaddr={miss_addr,2'b00}, ihit=0.
  - When iwait=0: write iload, the tag and valid=1 into the frame selected by miss_addr; next state IDLE.
  - When iwait=1: stay in FILL.
- Outside FILL: iREN=0, iaddr=0.
- Whenever ihit=0: imemload=0.
- A fill always completes once started, even if imemREN drops or imemaddr changes mid-fill. After the fill, IDLE re-evaluates the current address.
- Replacement: the new line unconditionally overwrites the indexed frame.
- No write path and no invalidate. Instruction memory is treated as immutable.

## Timing
- Hit latency: 0 cycles (combinational from imemaddr through the tag compare).
- Miss:
  - Cycle 0: miss detected in IDLE.
  - Cycle 1 onward: FILL with iREN=1.
  - Cycle k: first cycle with iwait=0; frame written at that clock edge.
  - Cycle k+1: IDLE, and ihit=1 if the address is unchanged.
  - Minimum miss penalty is 2 cycles (iwait=0 in the first FILL cycle).
- ihit is never asserted in FILL, even if iload matches the request.
- Reset asserted mid-fill: state→IDLE, iREN→0 and all valids cleared immediately (asynchronous). The partial fill is discarded.
- Reset values: ihit=0, imemload=0, iREN=0, iaddr=0.
- Outputs are glitch-free only relative to CLK. Consumers sample them at posedge.

## Configuration
- Macro: ICACHE_STATS_EN.
- Defined: adds output ports `hit_count` (32) and `miss_count` (32), both reset to 0.
  - hit_count increments every cycle ihit=1.
  - miss_count increments on every IDLE→FILL transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000000; memory holds iwait=1 for 2 FILL cycles, then iwait=0 with iload=0x20010004.
  - Required: iREN=1 and iaddr=0x0 for 3 cycles; ihit=0 throughout; the next cycle ihit=1 and imemload=0x20010004.
- Hit and conflict:
  - Stimulus: with 0x0 cached, imemaddr=0x00000040 (same index 0, different tag), filled with 0xAAAA5555; then return to 0x0.
  - Required: 0x40 misses then hits 0xAAAA5555; 0x0 misses again with iREN=1 and iaddr=0x0.
- Request drop mid-fill:
  - Stimulus: miss on 0x8, then imemREN=0 during FILL; iwait=0 with iload=0x12345678.
  - Required: the fill completes. A later imemREN=1 at 0x8 hits in 0 cycles with no iREN.
- Reset mid-fill:
  - Stimulus: assert nRST low while in FILL at 0xC.
  - Required: iREN=0 at once. After release, 0xC misses again and previously cached 0x0 also misses.
- Idle:
  - Stimulus: imemREN=0 for 10 cycles at any address.
  - Required: ihit=0, iREN=0, imemload=0.
- Statistics (with ICACHE_STATS_EN):
  - Stimulus: run the cold-miss scenario, then 4 further hit cycles.
  - Required: miss_count=1, hit_count=5.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
`ifdef ICACHE_STATS_EN
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`else
    input  logic [31:0] iload
`endif
);
    localparam int IDX = $clog2(NSETS);
    localparam int TAG = 30 - IDX;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]     state;
    logic [29:0]    miss_addr;
    logic           valid [NSETS];
    logic [TAG-1:0] tags  [NSETS];
    logic [31:0]    data  [NSETS];

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic [IDX-1:0] fidx;
    logic           hit;
    logic           miss;

    assign idx  = imemaddr[IDX+1:2];
    assign tag  = imemaddr[31:IDX+2];
    assign fidx = miss_addr[IDX-1:0];

    assign hit  = (state == IDLE) && imemREN
                  && valid[idx] && (tags[idx] == tag);
    assign miss = (state == IDLE) && imemREN && !hit;

    assign ihit     = hit;
    assign imemload = hit ? data[idx] : 32'h0;
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL) ? {miss_addr, 2'b00} : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        state     <= FILL;
                        miss_addr <= imemaddr[31:2];
                    end
                end
                FILL: begin
                    if (!iwait) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A fill completes regardless of what the datapath does meanwhile
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSETS; i++) begin
                valid[i] <= 1'b0;
                tags[i]  <= '0;
                data[i]  <= '0;
            end
        end else if (state == FILL && !iwait) begin
            valid[fidx] <= 1'b1;
            tags[fidx]  <= miss_addr[29:IDX];
            data[fidx]  <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (miss && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard testbench for icache: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    typedef struct {
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] addr;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    icache #(.NSETS(16)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
`ifdef ICACHE_STATS_EN
        .iload(iload),
        .hit_count(hit_count),
        .miss_count(miss_count)
`else
        .iload(iload)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".ihit"}, {31'b0, ihit}, {31'b0, e.hit});
            chk({e.name, ".imemload"}, imemload, e.load);
            chk({e.name, ".iREN"}, {31'b0, iREN}, {31'b0, e.ren});
            chk({e.name, ".iaddr"}, iaddr, e.addr);
        end
    end

    // Drive one cycle of inputs (at posedge+1) and queue expected outputs
    task automatic cyc(input string nm, input logic rst_n,
                       input logic ren, input logic [31:0] a,
                       input logic w, input logic [31:0] ld,
                       input logic eh, input logic [31:0] el,
                       input logic er, input logic [31:0] ea);
        exp_t e;
        nRST     = rst_n;
        imemREN  = ren;
        imemaddr = a;
        iwait    = w;
        iload    = ld;
        e.hit  = eh;
        e.load = el;
        e.ren  = er;
        e.addr = ea;
        e.name = nm;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        iwait = 1'b1;
        iload = '0;
        @(posedge CLK);
        #1;
        cyc("reset", 0, 1, 32'h0, 1, 0, 0, 0, 0, 0);

        // cold miss with two busy FILL cycles
        cyc("cold_idle", 1, 1, 32'h0, 1, 0, 0, 0, 0, 0);
        cyc("cold_f1", 1, 1, 32'h0, 1, 0, 0, 0, 1, 32'h0);
        cyc("cold_f2", 1, 1, 32'h0, 1, 0, 0, 0, 1, 32'h0);
        cyc("cold_f3", 1, 1, 32'h0, 0, 32'h20010004, 0, 0, 1, 32'h0);
        for (int i = 0; i < 5; i++)
            cyc("cold_hit", 1, 1, 32'h0, 1, 0, 1, 32'h20010004, 0, 0);
`ifdef ICACHE_STATS_EN
        chk("stats.hit_count", hit_count, 32'd5);
        chk("stats.miss_count", miss_count, 32'd1);
`endif

        // conflict at index 0
        cyc("conf_miss", 1, 1, 32'h40, 1, 0, 0, 0, 0, 0);
        cyc("conf_fill", 1, 1, 32'h40, 0, 32'hAAAA5555, 0, 0, 1, 32'h40);
        cyc("conf_hit", 1, 1, 32'h40, 1, 0, 1, 32'hAAAA5555, 0, 0);
        cyc("back_miss", 1, 1, 32'h0, 1, 0, 0, 0, 0, 0);
        cyc("back_f1", 1, 1, 32'h0, 1, 0, 0, 0, 1, 32'h0);
        cyc("back_f2", 1, 1, 32'h0, 0, 32'h20010004, 0, 0, 1, 32'h0);
        cyc("back_hit", 1, 1, 32'h0, 1, 0, 1, 32'h20010004, 0, 0);

        // request dropped mid-fill
        cyc("drop_miss", 1, 1, 32'h8, 1, 0, 0, 0, 0, 0);
        cyc("drop_f1", 1, 0, 32'h100, 1, 0, 0, 0, 1, 32'h8);
        cyc("drop_f2", 1, 0, 32'h104, 0, 32'h12345678, 0, 0, 1, 32'h8);
        cyc("drop_hit", 1, 1, 32'h8, 1, 0, 1, 32'h12345678, 0, 0);

        // idle on cached addresses
        for (int i = 0; i < 10; i++)
            cyc("idle", 1, 0, (i % 2) ? 32'h8 : 32'h0, 1, 0, 0, 0, 0, 0);

        // reset while filling 0xC
        cyc("rst_miss", 1, 1, 32'hC, 1, 0, 0, 0, 0, 0);
        cyc("rst_f1", 1, 1, 32'hC, 1, 0, 0, 0, 1, 32'hC);
        cyc("rst_async", 0, 1, 32'hC, 1, 0, 0, 0, 0, 0);
        cyc("rst_remiss", 1, 1, 32'hC, 1, 0, 0, 0, 0, 0);
        cyc("rst_fill", 1, 1, 32'hC, 0, 32'hDEADBEEF, 0, 0, 1, 32'hC);
        cyc("rst_hit", 1, 1, 32'hC, 1, 0, 1, 32'hDEADBEEF, 0, 0);
        cyc("rst_zero_miss", 1, 1, 32'h0, 1, 0, 0, 0, 0, 0);
        cyc("rst_zero_fill", 1, 1, 32'h0, 0, 32'h20010004, 0, 0, 1, 32'h0);
        cyc("rst_zero_hit", 1, 1, 32'h0, 1, 0, 1, 32'h20010004, 0, 0);

        imemREN = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
